// File: rtl/register_file.sv
// register_file: 8 x 32-bit register file with one synchronous write port
// and one combinational read port. There is no write-to-read bypass.
module register_file (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        we,
    input  logic [2:0]  wAddr,
    input  logic [31:0] wData,
    input  logic [2:0]  rAddr,
    output logic [31:0] rData
);

    localparam int unsigned DataWidth = 32;
    localparam int unsigned Depth     = 8;

    logic [Depth-1:0]     wSel;
    logic [Depth-1:0]     loadEn;
    logic [DataWidth-1:0] regs [Depth];

    // Write-address decode: one-hot select gated by the write enable
    always_comb begin
        wSel        = '0;
        wSel[wAddr] = 1'b1;
        loadEn      = wSel & {Depth{we}};
    end

    // Storage: reset (active-high despite the name) clears all entries and beats any write
    always_ff @(posedge clk) begin
        if (reset_n) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < Depth; i++) begin
                if (loadEn[i]) begin
                    regs[i] <= wData;
                end
            end
        end
    end

    // Read port: plain 8:1 mux on the current register contents
    always_comb begin
        rData = '0;
        case (rAddr)
            3'd0: rData = regs[0];
            3'd1: rData = regs[1];
            3'd2: rData = regs[2];
            3'd3: rData = regs[3];
            3'd4: rData = regs[4];
            3'd5: rData = regs[5];
            3'd6: rData = regs[6];
            3'd7: rData = regs[7];
            default: rData = '0;
        endcase
    end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: table of write/read vectors plus hand-written sequences
// for read-during-write, reset mid-burst and back-to-back random writes.
`timescale 1ns/1ps
module tb_register_file;

    logic        clk;
    logic        reset_n;
    logic        we;
    logic [2:0]  wAddr;
    logic [31:0] wData;
    logic [2:0]  rAddr;
    logic [31:0] rData;

    int unsigned testsRun;
    int unsigned testsFailed;
    logic [31:0] sbQ[$];
    logic [31:0] model [8];

    register_file dut (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (we),
        .wAddr   (wAddr),
        .wData   (wData),
        .rAddr   (rAddr),
        .rData   (rData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          doEdge;
        bit          rst;
        bit          wen;
        logic [2:0]  wa;
        logic [31:0] wd;
        logic [2:0]  ra;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit e, bit r, bit w, logic [2:0] wa, logic [31:0] wd,
                                logic [2:0] ra, logic [31:0] ex);
        vec_t v;
        v.doEdge = e; v.rst = r; v.wen = w; v.wa = wa; v.wd = wd; v.ra = ra; v.exp = ex;
        return v;
    endfunction

    // Push expectation, present address, pop and compare after settle
    task automatic readCheck(input logic [2:0] a, input logic [31:0] e, input string nm);
        logic [31:0] got;
        logic [31:0] want;
        rAddr = a;
        sbQ.push_back(e);
        #1;
        got  = rData;
        want = sbQ.pop_front();
        testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("FAIL %s rAddr=%0d got=%08h expected=%08h", nm, a, got, want);
        end
    endtask

    // Drive write-side inputs, take one rising edge, then idle the write side
    task automatic doEdge(input bit r, input bit w, input logic [2:0] wa, input logic [31:0] wd);
        reset_n = r; we = w; wAddr = wa; wData = wd;
        @(posedge clk);
        #1;
        reset_n = 1'b0; we = 1'b0;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset_n = 1'b0; we = 1'b0; wAddr = 3'd0; wData = 32'h0; rAddr = 3'd0;
        @(negedge clk);

        // Reset with write pending, then sweep
        vecs.push_back(mk(1, 1, 1, 3'd0, 32'h11111111, 3'd0, 32'h00000000));
        for (int i = 1; i < 8; i++) vecs.push_back(mk(0, 0, 0, 3'd0, 32'h0, 3'(i), 32'h00000000));
        // Basic and sequential writes
        vecs.push_back(mk(1, 0, 1, 3'd0, 32'h11111111, 3'd0, 32'h11111111));
        vecs.push_back(mk(1, 0, 1, 3'd1, 32'hff00ff00, 3'd1, 32'hff00ff00));
        vecs.push_back(mk(1, 0, 1, 3'd2, 32'hff00ff00, 3'd2, 32'hff00ff00));
        vecs.push_back(mk(1, 0, 1, 3'd3, 32'h0000ffff, 3'd3, 32'h0000ffff));
        for (int i = 4; i < 8; i++) vecs.push_back(mk(0, 0, 0, 3'd0, 32'h0, 3'(i), 32'h00000000));
        vecs.push_back(mk(0, 0, 0, 3'd0, 32'h0, 3'd0, 32'h11111111));
        vecs.push_back(mk(0, 0, 0, 3'd0, 32'h0, 3'd1, 32'hff00ff00));
        // Write disabled over several edges
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 0, 3'd1, 32'hdeadbeef, 3'd1, 32'hff00ff00));

        foreach (vecs[k]) begin
            if (vecs[k].doEdge) doEdge(vecs[k].rst, vecs[k].wen, vecs[k].wa, vecs[k].wd);
            readCheck(vecs[k].ra, vecs[k].exp, $sformatf("vec%0d", k));
        end

        // Read-during-write on the same address: old value before edge, new after
        @(posedge clk); #1;
        rAddr = 3'd5; wAddr = 3'd5; we = 1'b1; wData = 32'hcafef00d;
        readCheck(3'd5, 32'h00000000, "rdw_before");
        @(posedge clk); #1;
        we = 1'b0;
        readCheck(3'd5, 32'hcafef00d, "rdw_after");
        readCheck(3'd4, 32'h00000000, "rdw_neighbour");

        // Reset mid-burst: everything clears and the pending write to 7 is dropped
        doEdge(1'b0, 1'b1, 3'd6, 32'h66666666);
        doEdge(1'b1, 1'b1, 3'd7, 32'h12345678);
        for (int i = 0; i < 8; i++) readCheck(3'(i), 32'h00000000, $sformatf("rstburst%0d", i));
        doEdge(1'b0, 1'b1, 3'd7, 32'h12345678);
        readCheck(3'd7, 32'h12345678, "post_reset_write");
        readCheck(3'd0, 32'h00000000, "post_reset_other");

        // Back-to-back random writes against a reference array, incl. repeated address
        for (int i = 0; i < 8; i++) model[i] = 32'h0;
        model[7] = 32'h12345678;
        @(posedge clk); #1;
        for (int n = 0; n < 24; n++) begin
            logic [2:0]  a;
            logic [31:0] d;
            a = (n == 1) ? 3'd2 : 3'($urandom_range(0, 7));
            if (n == 0) a = 3'd2;
            d = $urandom;
            reset_n = 1'b0; we = 1'b1; wAddr = a; wData = d;
            model[a] = d;
            @(posedge clk); #1;
        end
        we = 1'b0;
        for (int i = 0; i < 8; i++) readCheck(3'(i), model[i], $sformatf("burst%0d", i));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
